// File: rtl/rv_mem_resp.sv
// Memory responder for the multicycle RISC-V core: captures one word request, waits
// WAIT_CYCLES, accesses the internal array, and returns a one-cycle ack.
// Optional feature macro: RV_MEM_ERR_EN (flag misaligned / out-of-range accesses with err).
module rv_mem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memrw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        memrw_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc_en;
  logic          use_live;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_off;
  logic [AW-1:0] acc_idx;
  logic          acc_bad;

  // With zero wait states the access happens on the capture edge itself,
  // so the live inputs are used instead of the not-yet-loaded capture registers.
  assign use_live  = (state_reg == IDLE);
  assign acc_we    = use_live ? memrw : memrw_reg;
  assign acc_addr  = use_live ? addr  : addr_reg;
  assign acc_wdata = use_live ? wdata : wdata_reg;
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_idx   = acc_off[AW+1:2];

`ifdef RV_MEM_ERR_EN
  assign acc_bad = (acc_addr[1:0] != 2'b00) ||
                   ({1'b0, acc_off} >= (33'(DEPTH_WORDS) << 2));
`else
  logic unused_off_bits;
  assign unused_off_bits = ^{acc_off[31:AW+2], acc_off[1:0]};
  assign acc_bad = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            acc_en     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = RESP;
          acc_en     = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request fields are only sampled in IDLE; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      memrw_reg <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
    end else if (state_reg == IDLE && req) begin
      memrw_reg <= memrw;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

  // A reset on the access edge discards the write.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && !acc_bad && !rst) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= 32'h0;
    end else if (acc_en && !acc_we) begin
      rdata_reg <= acc_bad ? 32'h0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (acc_en) begin
      err_reg <= acc_bad;
    end
  end

  assign ack   = (state_reg == RESP);
  assign busy  = (state_reg != IDLE);
  assign err   = ack & err_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp: a default instance (2 wait states) and a zero-wait instance.
module tb_rv_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, memrw_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        ack_a, err_a, busy_a;
  logic        req_z, memrw_z;
  logic [31:0] addr_z, wdata_z, rdata_z;
  logic        ack_z, err_z, busy_z;

  int n_vec = 0;
  int n_bad = 0;

  rv_mem_resp dut_a (
    .clk(clk), .rst(rst), .req(req_a), .memrw(memrw_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  rv_mem_resp #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .memrw(memrw_z), .addr(addr_z),
    .wdata(wdata_z), .rdata(rdata_z), .ack(ack_z), .err(err_z), .busy(busy_z)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request on dut_a and reports what came back; chg swaps addr/wdata after capture.
  task automatic access_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic chg, input logic [31:0] a2, input logic [31:0] d2,
                          output int lat, output int nbusy,
                          output logic [31:0] rd, output logic e);
    lat = -1; nbusy = 0; rd = 'x; e = 'x;
    @(posedge clk); #1;
    req_a = 1'b1; memrw_a = w; addr_a = a; wdata_a = d;
    @(posedge clk); #1;
    if (chg) begin
      addr_a = a2; wdata_a = d2;
    end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy_a) nbusy++;
      if (ack_a) begin
        lat = c; rd = rdata_a; e = err_a;
        break;
      end
    end
    @(posedge clk); #1;
    req_a = 1'b0;
    $display("access %s addr=%h wdata=%h -> lat=%0d busy=%0d rdata=%h err=%b",
             w ? "WR" : "RD", a, d, lat, nbusy, rd, e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_a = 0; memrw_a = 0; addr_a = 0; wdata_a = 0;
    req_z = 0; memrw_z = 0; addr_z = 0; wdata_z = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ack_a !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b exp 0", ack_a); end
    n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_vec++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", rdata_a); end
    n_vec++; if (busy_z !== 1'b0) begin n_bad++; $display("FAIL reset_busy_z got %b exp 0", busy_z); end
    rst = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_write_read;
    int lat, nb; logic [31:0] rd; logic e;
    access_a(1'b1, 32'h10, 32'h11223344, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency got %0d exp 3", lat); end
    n_vec++; if (nb !== 3) begin n_bad++; $display("FAIL wr_busy_cycles got %0d exp 3", nb); end
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wr_rdata_hold got %h exp 0", rd); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b exp 0", e); end
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL busy_after_ack got %b exp 0", busy_a); end
    access_a(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency got %0d exp 3", lat); end
    n_vec++; if (nb !== 3) begin n_bad++; $display("FAIL rd_busy_cycles got %0d exp 3", nb); end
    n_vec++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rd_data got %h exp 11223344", rd); end
  endtask

  task automatic test_back_to_back;
    logic        w_t [6];
    logic [31:0] a_t [6];
    logic [31:0] d_t [6];
    logic [31:0] exp_rd [6];
    int acks = 0;
    w_t    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    a_t    = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h48, 32'h48};
    d_t    = '{32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0, 32'h55, 32'h0};
    exp_rd = '{32'h0, 32'h0, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0002, 32'h55};
    @(posedge clk); #1;
    req_z = 1'b1; memrw_z = w_t[0]; addr_z = a_t[0]; wdata_z = d_t[0];
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (ack_z) begin
        $display("b2b ack %0d at cycle %0d rdata=%h err=%b", acks, cyc, rdata_z, err_z);
        n_vec++; if (cyc !== 2 * acks + 1) begin n_bad++; $display("FAIL b2b_ack_cycle got %0d exp %0d", cyc, 2 * acks + 1); end
        n_vec++; if (rdata_z !== exp_rd[acks]) begin n_bad++; $display("FAIL b2b_rdata got %h exp %h", rdata_z, exp_rd[acks]); end
        n_vec++; if (err_z !== 1'b0) begin n_bad++; $display("FAIL b2b_err got %b exp 0", err_z); end
        acks++;
        @(posedge clk); #1;
        if (acks < 6) begin
          memrw_z = w_t[acks]; addr_z = a_t[acks]; wdata_z = d_t[acks];
        end else begin
          req_z = 1'b0;
        end
      end
    end
    n_vec++; if (acks !== 6) begin n_bad++; $display("FAIL b2b_ack_count got %0d exp 6", acks); end
  endtask

  task automatic test_reset_in_wait;
    int lat, nb; logic [31:0] rd; logic e;
    logic saw_ack = 1'b0;
    access_a(1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    access_a(1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL rst_pre_read got %h exp 0badf00d", rd); end
    @(posedge clk); #1;
    req_a = 1'b1; memrw_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rst_in_wait_busy got %b exp 1", busy_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset asserted during WAIT of write 0xdeadbeef to 0x20");
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_abort_busy got %b exp 0", busy_a); end
    n_vec++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_abort_rdata got %h exp 0", rdata_a); end
    for (int c = 0; c < 6; c++) begin
      if (ack_a) saw_ack = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_ack !== 1'b0) begin n_bad++; $display("FAIL rst_abort_ack got %b exp 0", saw_ack); end
    access_a(1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL rst_post_read got %h exp 0badf00d", rd); end
  endtask

  task automatic test_input_change;
    int lat, nb; logic [31:0] rd; logic e;
    access_a(1'b1, 32'hC, 32'h77, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    access_a(1'b1, 32'h8, 32'h5, 1'b1, 32'hC, 32'h9, lat, nb, rd, e);
    access_a(1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'h5) begin n_bad++; $display("FAIL chg_mem8 got %h exp 5", rd); end
    access_a(1'b0, 32'hC, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'h77) begin n_bad++; $display("FAIL chg_memC got %h exp 77", rd); end
  endtask

`ifdef RV_MEM_ERR_EN
  task automatic test_err;
    int lat, nb; logic [31:0] rd; logic e;
    access_a(1'b1, 32'h0, 32'h13572468, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_ok_wr got %b exp 0", e); end
    access_a(1'b1, 32'h1002, 32'hFFFF0000, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_wr_1002 got %b exp 1", e); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL err_wr_latency got %0d exp 3", lat); end
    access_a(1'b1, 32'h12, 32'hEEEEEEEE, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_wr_misalign got %b exp 1", e); end
    access_a(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'h13572468) begin n_bad++; $display("FAIL err_mem0_kept got %h exp 13572468", rd); end
    access_a(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL err_mem10_kept got %h exp 11223344", rd); end
    access_a(1'b0, 32'h1000, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_rd_1000 got %b exp 1", e); end
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_rd_data got %h exp 0", rd); end
    access_a(1'b1, 32'hFFC, 32'h0FFC0FFC, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    access_a(1'b0, 32'hFFC, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_rd_ffc got %b exp 0", e); end
    n_vec++; if (rd !== 32'h0FFC0FFC) begin n_bad++; $display("FAIL err_rd_ffc_data got %h exp 0ffc0ffc", rd); end
  endtask
`else
  task automatic test_wrap;
    int lat, nb; logic [31:0] rd; logic e;
    access_a(1'b1, 32'h1004, 32'hA5, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL wrap_wr_err got %b exp 0", e); end
    access_a(1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'hA5) begin n_bad++; $display("FAIL wrap_rd_data got %h exp a5", rd); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL wrap_rd_err got %b exp 0", e); end
    access_a(1'b0, 32'h6, 32'h0, 1'b0, 32'h0, 32'h0, lat, nb, rd, e);
    n_vec++; if (rd !== 32'hA5) begin n_bad++; $display("FAIL wrap_misalign_data got %h exp a5", rd); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL wrap_misalign_err got %b exp 0", e); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_in_wait();
    test_input_change();
`ifdef RV_MEM_ERR_EN
    test_err();
`else
    test_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
